// File: rtl/mips_defs.sv
// mips_defs: shared state encoding and sizing constants for the divide sequencer.
package mips_defs;
    localparam int WIDTH = 32;
    localparam int DIV_STEPS = 32;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle between the E stage and the divide sequencer.
interface div_seq_if #(parameter int WIDTH = mips_defs::WIDTH);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    modport master(output start, signed_div, annul, a, b, input busy, valid, lo, hi);
    modport slave(input start, signed_div, annul, a, b, output busy, valid, lo, hi);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration.
module div_step #(parameter int WIDTH = mips_defs::WIDTH) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    logic           ge;
    assign sh       = {rem, q[WIDTH-1]};
    assign diff     = sh - {1'b0, divisor};
    assign ge       = ~diff[WIDTH];
    assign rem_next = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    assign q_next   = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 DIV/DIVU sequencer returning quotient (lo) and remainder (hi).
module div_seq import mips_defs::*; #(
    parameter int WIDTH = mips_defs::WIDTH,
    parameter int CNT_W = 5
) (
    input logic       clk,
    input logic       resetn,
    div_seq_if.slave  bus
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, q, dvs, rem_n, q_n;
    logic             qneg, rneg, zero;
    logic             a_neg, b_neg;
    assign a_neg     = bus.signed_div & bus.a[WIDTH-1];
    assign b_neg     = bus.signed_div & bus.b[WIDTH-1];
    assign bus.busy  = ~bus.annul & ((state == BUSY) | ((state == IDLE) & bus.start));
    assign bus.valid = ~bus.annul & (state == DONE);
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem), .q(q), .divisor(dvs), .rem_next(rem_n), .q_next(q_n)
    );
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            q      <= '0;
            dvs    <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            zero   <= 1'b0;
            bus.lo <= '0;
            bus.hi <= '0;
        end else if (bus.annul) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    q     <= a_neg ? -bus.a : bus.a;
                    dvs   <= b_neg ? -bus.b : bus.b;
                    qneg  <= a_neg ^ b_neg;
                    rneg  <= a_neg;
                    zero  <= (bus.b == '0);
                    rem   <= '0;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    rem <= rem_n;
                    q   <= q_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIV_STEPS - 1)) begin
                        state  <= DONE;
                        // with a zero divisor the remainder is |a|, so re-signing it reproduces a
                        bus.lo <= zero ? '1 : (qneg ? -q_n : q_n);
                        bus.hi <= rneg ? -rem_n : rem_n;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_div_seq;
    import mips_defs::*;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    div_seq_if bus();
    div_seq dut(.clk(clk), .resetn(resetn), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [63:0] e;
    always @(negedge clk) begin
        if (bus.valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid=%b lo=%h hi=%h want no valid", bus.valid, bus.lo, bus.hi);
            end else begin
                e = exp_q.pop_front();
                chk("lo", bus.lo, e[63:32]);
                chk("hi", bus.hi, e[31:0]);
            end
        end
    end

    task automatic run_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] elo, input logic [31:0] ehi);
        int n = 0;
        int cyc = 0;
        bit seen = 0;
        bus.start = 1'b1;
        bus.signed_div = sd;
        bus.a = av;
        bus.b = bv;
        exp_q.push_back({elo, ehi});
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen = 1;
            else begin
                cyc++;
                if (bus.busy === 1'b1) n++;
            end
        end
        chk("valid_latency", cyc, 33);
        chk("busy_cycles", n, 33);
        chk("busy_in_done", {31'd0, bus.busy}, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_done", {30'd0, bus.busy, bus.valid}, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_valid", {31'd0, bus.valid}, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_hi", bus.hi, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        run_div(1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234);
        run_div(1'b1, 32'hFFFFFF00, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF00);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        // abandon a divide at BUSY iteration 10, then restart immediately
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd100;
        bus.b = 32'd7;
        repeat (11) @(posedge clk);
        #1 bus.annul = 1'b1;
        @(negedge clk);
        chk("annul_busy", {31'd0, bus.busy}, 0);
        chk("annul_valid", {31'd0, bus.valid}, 0);
        @(posedge clk);
        #1 bus.annul = 1'b0;
        chk("annul_state", {30'd0, dut.state}, {30'd0, IDLE});
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
        // reset pulse at BUSY iteration 20
        bus.start = 1'b1;
        bus.a = 32'd100;
        bus.b = 32'd7;
        repeat (21) @(posedge clk);
        #1 resetn = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, bus.busy}, 0);
        chk("rst_mid_valid", {31'd0, bus.valid}, 0);
        chk("rst_mid_lo", bus.lo, 0);
        chk("rst_mid_hi", bus.hi, 0);
        @(posedge clk);
        #1;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        chk("pending_results", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 divide sequencer for the MIPS execute stage.
- Accepts a DIV/DIVU request from E, runs a 32-step shift-subtract datapath, and returns quotient (LO) and remainder (HI).
- Its busy output drives the hazard unit's divide stall, replacing the raw divE term. The stall is released exactly on the done cycle.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  divide instruction valid in E (divE); level, held while stalled.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend; sampled on accept.
- b  in  WIDTH  divisor; sampled on accept.
- annul  in  1  flush/exception; cancels any operation in flight.
- busy  out  1  stall request to hazard unit (divbusyE).
- valid  out  1  one-cycle result strobe.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, counter=0. Outputs go to busy=0, valid=0, lo=0, hi=0. Reset mid-operation abandons the divide with no valid.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 and annul=0: latch |a|, |b|, quotient sign (a[31]^b[31] when signed), remainder sign (a[31] when signed), and the b==0 flag. Clear the partial remainder and go to BUSY. In unsigned mode the magnitudes are the raw operands.
- busy is combinational: (state==BUSY) | (state==IDLE & start & ~annul). This asserts the stall in the same cycle the instruction reaches E.
- BUSY: one shift-subtract step per cycle, counter 0..31. Restoring algorithm: rem = {rem, q_msb}; if rem >= divisor, subtract and set the quotient bit to 1. After step 31, go to DONE.
- DONE: busy=0, valid=1 for exactly one cycle, lo/hi hold the final results. Next state is IDLE unconditionally. start is ignored in DONE, because the same instruction is still in E this cycle and must not restart.
- Latency: accept at cycle N; BUSY occupies cycles N+1..N+32; valid is high at cycle N+33. busy is high for cycles N..N+32 (33 cycles total).
- Sign fixup is applied at the BUSY→DONE transition: negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set.
- Divide by zero: full latency is still used, with no exception. Result is lo=all ones, hi=a as originally presented; sign fixup is skipped.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of 32-bit unsigned magnitudes; no special case is needed.
- annul in any state: next state is IDLE, valid is suppressed that cycle and thereafter, and busy is 0 in the annul cycle. annul has priority over start and over the DONE transition.
- lo/hi retain their last values outside DONE; consumers must sample them only on valid.

Decomposition:
- Shared package (mips_defs) holds:
  - the state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - the DIV_STEPS=32 constant;
  - the WIDTH default.
- Sub-module div_step: purely combinational single iteration. Inputs are partial remainder, quotient shift register and divisor; outputs are the next remainder and next quotient.
- div_seq owns the FSM, counter, operand/sign registers and fixup.

Test Plan:
- Unsigned: a=100, b=7, start held → busy high 33 cycles; valid at cycle 33 with lo=14, hi=2; no second valid while start remains high through DONE.
- Signed: a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Divide by zero: DIVU a=0x1234, b=0 → valid at cycle 33, lo=0xFFFFFFFF, hi=0x1234.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- annul at BUSY iteration 10 → busy drops in the annul cycle, no valid ever appears, state is IDLE. A new start on the next cycle (a=9, b=3) produces lo=3, hi=0 with full latency.
- resetn=0 for one cycle at iteration 20 → all outputs 0 next cycle, no valid. A subsequent start behaves normally.
